instr_fetch_unit: RTL

//  Fetch stage ahead of the control unit/decoder. Owns the architectural PC and issues in-order

---
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that owns the PC, issues in-order word reads to
// instruction memory and buffers returned words in a small FIFO for decode.
// A redirect flushes the FIFO and discards reads already in flight.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  // state | meaning
  // BOOT  | quiet cycle after reset release (held while a redirect is applied); no request
  // RUN   | issue requests whenever buffer + in-flight reads leave a free slot

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, resp_pc_q, target_pc;
  logic [CNT_W-1:0]  outstanding_q, drop_q, count_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [31:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic              pop, issue, resp_live, resp_drop, push;
  logic [SUM_W-1:0]  in_use;

  assign target_pc   = redirect_pc & ~ADDR_W'(3);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  assign pop       = instr_valid & instr_ready;
  assign issue     = imem_req & imem_ready;
  // responses with nothing outstanding (e.g. stale data after reset) are ignored
  assign resp_live = imem_rvalid & (outstanding_q != '0);
  assign resp_drop = resp_live & ((drop_q != '0) | redirect);
  assign push      = resp_live & ~resp_drop;
  // a pop this cycle frees its slot, so a 1-cycle memory can stream without bubbles
  assign in_use    = SUM_W'(count_q) + SUM_W'(outstanding_q) - SUM_W'(pop);

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  // next state and request qualification
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      BOOT:    if (!redirect) state_d = RUN;
      RUN:     imem_req = !redirect && (in_use < SUM_W'(DEPTH));
      default: state_d = BOOT;
    endcase
  end

  // fetch PC and the PC tag of the next kept response (responses return in order)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= target_pc;
      resp_pc_q  <= target_pc;
    end else begin
      if (issue) fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
      if (push)  resp_pc_q  <= resp_pc_q + ADDR_W'(4);
    end
  end

  // in-flight read count and number of in-flight reads still to be discarded
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(resp_live);
      if (redirect)       drop_q <= outstanding_q - CNT_W'(resp_live);
      else if (resp_drop) drop_q <= drop_q - CNT_W'(1);
    end
  end

  // instruction FIFO; a redirect empties it (a same-cycle pop has already been consumed)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (redirect) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] flushed, drop_inc;
  logic [32:0] dropped_sum;

  assign flushed     = redirect ? (32'(count_q) - 32'(pop)) : 32'd0;
  assign drop_inc    = flushed + 32'(resp_drop);
  assign dropped_sum = {1'b0, perf_dropped} + {1'b0, drop_inc};

  // saturating event counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      perf_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
    end
  end
`endif

endmodule
